// File: rtl/decode_instr_queue_pkg.sv
// decode_instr_queue_pkg: shared decode-stage types and queue sizing
`ifndef DEC_WIDTH
`define DEC_WIDTH 4
`endif

package decode_instr_queue_pkg;
   localparam int DIQ_DEPTH = 16;

   typedef struct packed {
      logic        valid;
      logic [15:0] pc;
      logic [31:0] instr;
   } PD_Instr;
endpackage

// File: rtl/diq_lane_compact.sv
// diq_lane_compact: prefix-sum of input valid bits giving each lane's compacted slot offset
module diq_lane_compact #(
   parameter int DEC_WIDTH = `DEC_WIDTH
) (
   input  logic [DEC_WIDTH-1:0]                        validMask,
   output logic [DEC_WIDTH-1:0][$clog2(DEC_WIDTH)-1:0] laneOffset,
   output logic [$clog2(DEC_WIDTH):0]                  laneCount
);
   localparam int OFF_W = $clog2(DEC_WIDTH);

   // running count of valid lanes below each lane is that lane's destination offset
   always_comb begin
      laneCount = '0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
         laneOffset[i] = laneCount[OFF_W-1:0];
         laneCount = laneCount + {{OFF_W{1'b0}}, validMask[i]};
      end
   end
endmodule

// File: rtl/decode_instr_queue.sv
// decode_instr_queue: elastic compacting buffer between instruction aligner and decoder
module decode_instr_queue
   import decode_instr_queue_pkg::*;
#(
   parameter int DEC_WIDTH = `DEC_WIDTH,
   parameter int DEPTH     = DIQ_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    IN_clear,
   input  PD_Instr                 IN_instrs[DEC_WIDTH],
   output logic                    OUT_ready,
   input  logic                    IN_ready,
   output PD_Instr                 OUT_instrs[DEC_WIDTH],
   output logic [$clog2(DEPTH):0]  OUT_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam int OFF_W = $clog2(DEC_WIDTH);
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] WIDTH_C = DEC_WIDTH[PTR_W:0];

   PD_Instr storage[DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [PTR_W:0] count, countNext, enqCnt, deqCnt;
   logic [DEC_WIDTH-1:0] inValid;
   logic [DEC_WIDTH-1:0][OFF_W-1:0] laneOff;
   logic [OFF_W:0] laneTotal;
   logic doEnq, doDeq;

   diq_lane_compact #(.DEC_WIDTH(DEC_WIDTH)) compact (
      .validMask (inValid),
      .laneOffset(laneOff),
      .laneCount (laneTotal)
   );

   // gather lane valid bits for the compactor
   always_comb begin
      for (int i = 0; i < DEC_WIDTH; i++) inValid[i] = IN_instrs[i].valid;
   end

   // ready comes from registered occupancy only, so it never depends on decoder ready
   assign OUT_ready = (DEPTH_C - count) >= WIDTH_C;
   assign doEnq     = OUT_ready && !IN_clear;
   assign doDeq     = IN_ready && !IN_clear;
   assign enqCnt    = doEnq ? CW'(laneTotal) : '0;
   assign deqCnt    = doDeq ? ((count > WIDTH_C) ? WIDTH_C : count) : '0;
   assign countNext = count + enqCnt - deqCnt;
   assign OUT_count = count;

   // pointer and occupancy update; flush takes priority over enqueue/dequeue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (IN_clear) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         rdPtr <= rdPtr + deqCnt[PTR_W-1:0];
         wrPtr <= wrPtr + enqCnt[PTR_W-1:0];
         count <= countNext;
      end
   end

   // write valid lanes into consecutive slots from wrPtr, squeezing out gaps
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEC_WIDTH; i++)
         if (doEnq && IN_instrs[i].valid) storage[wrPtr + PTR_W'(laneOff[i])] <= IN_instrs[i];
   end

   // present the oldest entries; lanes beyond occupancy are invalid with undefined payload
   always_comb begin
      for (int i = 0; i < DEC_WIDTH; i++) begin
         OUT_instrs[i] = (count > CW'(i)) ? storage[rdPtr + PTR_W'(i)] : 'x;
         OUT_instrs[i].valid = count > CW'(i);
      end
   end

   countBounded: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
   noValidWhenFull: assert property (@(posedge clk) disable iff (rst) !OUT_ready |-> !(|inValid))
      else $warning("aligner presented valid lanes while queue not ready");
endmodule
